// File: rtl/led_seg7_scan.sv
// ----------------------------------------------------------------------------
// led_seg7_scan
//
// Time-multiplexed driver for a common-anode 7-segment bank. Each digit gets
// a slot of SCAN_DIV clock cycles: SCAN_DIV-1 cycles lit, then one dark cycle
// so the previous digit's segments never bleed into the next anode (ghosting).
// Display data is captured into shadow registers on a one-cycle load strobe,
// so the CPU can rewrite its display register without tearing the frame.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   data_in     hex nibbles, digit i = data_in[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point per digit, 1 = lit
//   digit_en    per-digit enable (live), 0 keeps that anode off
//   blank_lead  suppress leading zeros (live)
//   load        one-cycle strobe capturing data_in/dp_in
//   AN          anode selects, active low
//   data_out    segments {dp,g,f,e,d,c,b,a}, active low
// ----------------------------------------------------------------------------
module led_seg7_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    blank_lead,
   input  logic                    load,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [7:0]              data_out
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // Elaboration-time guard against illegal parameter combinations.
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("led_seg7_scan: NUM_DIGITS must be 1..8");
   end
   if (SCAN_DIV < 2) begin : g_bad_div
      $error("led_seg7_scan: SCAN_DIV must be >= 2");
   end
   if ((64'd1 << CNT_W) < 64'(SCAN_DIV)) begin : g_bad_cntw
      $error("led_seg7_scan: CNT_W too narrow for SCAN_DIV");
   end

   // -------------------------------------------------------------------------
   // Hex to segment decode, active low {g,f,e,d,c,b,a}.
   // -------------------------------------------------------------------------
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'ha:    seg = 7'h08;
         4'hb:    seg = 7'h03;
         4'hc:    seg = 7'h46;
         4'hd:    seg = 7'h21;
         4'he:    seg = 7'h06;
         default: seg = 7'h0e;
      endcase
      return seg;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [4*NUM_DIGITS-1:0] data_q, data_d;
   logic [NUM_DIGITS-1:0]   dp_q,   dp_d;
   logic [CNT_W-1:0]        presc_q, presc_d;
   logic [IDX_W-1:0]        idx_q,   idx_d;
   logic [NUM_DIGITS-1:0]   an_q,    an_d;
   logic [7:0]              seg_q,   seg_d;

   // Per-digit suppression flags and the currently selected digit's view.
   logic [NUM_DIGITS-1:0]   sup;
   logic                    lz_run;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_en;
   logic                    cur_sup;
   logic [NUM_DIGITS-1:0]   cur_an;
   logic                    slot_end;

   assign slot_end = (presc_q == PRESC_LAST);

   // -------------------------------------------------------------------------
   // Leading-zero suppression. Walk from the leftmost digit down; a digit is
   // blank only while every digit to its left (and itself) is a zero nibble
   // with no decimal point. A lit dp counts as content, so "0.5" keeps its 0.
   // Digit 0 always shows so an all-zero value still reads "0".
   // -------------------------------------------------------------------------
   always_comb begin
      sup    = '0;
      lz_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz_run = lz_run && (data_q[4*i +: 4] == 4'h0) && !dp_q[i];
         if (i != 0) sup[i] = blank_lead && lz_run;
      end
   end

   // -------------------------------------------------------------------------
   // Digit select mux, written as a compare loop so any NUM_DIGITS works
   // without out-of-range part selects.
   // -------------------------------------------------------------------------
   always_comb begin
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      cur_en  = 1'b0;
      cur_sup = 1'b0;
      cur_an  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib   = data_q[4*i +: 4];
            cur_dp    = dp_q[i];
            cur_en    = digit_en[i];
            cur_sup   = sup[i];
            cur_an[i] = 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // Shadow capture
      data_d = load ? data_in : data_q;
      dp_d   = load ? dp_in   : dp_q;

      // Prescaler and digit index; the index steps on the last slot cycle.
      presc_d = presc_q + CNT_W'(1);
      idx_d   = idx_q;
      if (slot_end) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end

      // Output register. The last slot cycle is forced dark: that is the
      // anti-ghosting gap while the anode switches.
      if (slot_end || !cur_en || cur_sup) begin
         an_d  = '1;
         seg_d = 8'hff;
      end else begin
         an_d  = cur_an;
         seg_d = {~cur_dp, hex_decode(cur_nib)};
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         dp_q    <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         an_q    <= '1;
         seg_q   <= 8'hff;
      end else begin
         data_q  <= data_d;
         dp_q    <= dp_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign AN       = an_q;
   assign data_out = seg_q;

endmodule

// File: tb/tb_led_seg7_scan.sv
// ----------------------------------------------------------------------------
// tb_led_seg7_scan
//
// Directed bench for led_seg7_scan with NUM_DIGITS=4, SCAN_DIV=4. Outputs are
// sampled 1 time unit after each rising edge; inputs change right after the
// sample so they are stable well before the next edge.
// ----------------------------------------------------------------------------
module tb_led_seg7_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        blank_lead;
   logic        load;
   logic [3:0]  AN;
   logic [7:0]  data_out;

   int nvec = 0;
   int nerr = 0;

   led_seg7_scan #(
      .NUM_DIGITS (4),
      .SCAN_DIV   (4),
      .CNT_W      (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .blank_lead (blank_lead),
      .load       (load),
      .AN         (AN),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
      nvec++;
      assert (AN === an_e)
      else begin
         nerr++;
         $error("FAIL %s AN got %b exp %b", tag, AN, an_e);
      end
      nvec++;
      assert (data_out === seg_e)
      else begin
         nerr++;
         $error("FAIL %s data_out got %h exp %h", tag, data_out, seg_e);
      end
   endtask

   // Starts with prescaler=1, idx=0 (state right after a restart or a frame).
   // Walks the rest of digit 0's slot, digits 1..3, then one edge into the
   // next frame's digit 0.
   task automatic frame(input string tag, input logic [3:0][3:0] an_e,
                        input logic [3:0][7:0] seg_e);
      for (int d = 0; d < 4; d++) begin
         for (int c = (d == 0) ? 1 : 0; c < 4; c++) begin
            step();
            if (c == 3) chk(tag, 4'hf, 8'hff);
            else        chk(tag, an_e[d], seg_e[d]);
         end
      end
      step();
      chk(tag, an_e[0], seg_e[0]);
   endtask

   // Reset one cycle, then load new shadow data at the first edge after
   // release. Leaves prescaler=1, idx=0.
   task automatic restart(input logic [15:0] d, input logic [3:0] p);
      rst  = 1'b1;
      load = 1'b0;
      step();
      chk("restart_rst", 4'hf, 8'hff);
      rst     = 1'b0;
      data_in = d;
      dp_in   = p;
      load    = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      data_in    = 16'h0;
      dp_in      = 4'h0;
      digit_en   = 4'hf;
      blank_lead = 1'b0;
      load       = 1'b0;

      // Reset held two cycles
      step();
      step();
      chk("reset", 4'hf, 8'hff);
      rst = 1'b0;
      step();
      chk("release", 4'b1110, 8'hc0);

      // Scan order 1234
      restart(16'h1234, 4'h0);
      frame("scan", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {8'hf9,   8'ha4,   8'hb0,   8'h99});

      // Load latency: new data shows one edge after the strobe edge
      data_in = 16'h0008;
      load    = 1'b1;
      step();
      chk("load_edge", 4'b1110, 8'h99);
      load = 1'b0;
      step();
      chk("load_next", 4'b1110, 8'h80);

      // Decimal point on digit 1
      restart(16'h00a0, 4'b0010);
      frame("dp", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                  {8'hc0,   8'hc0,   8'h08,   8'hc0});

      // Leading-zero suppression
      blank_lead = 1'b1;
      restart(16'h0005, 4'h0);
      frame("supp", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {8'hff,   8'hff,   8'hff,   8'h92});
      blank_lead = 1'b0;
      frame("nosupp", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                      {8'hc0,   8'hc0,   8'hc0,   8'h92});

      // A lit dp on a leading zero stops suppression at that digit
      blank_lead = 1'b1;
      restart(16'h0005, 4'b0100);
      frame("supp_dp", {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                       {8'hff,   8'h40,   8'hc0,   8'h92});
      blank_lead = 1'b0;

      // Digit enable mask
      digit_en = 4'b1011;
      restart(16'hffff, 4'h0);
      frame("digit_en", {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                        {8'h8e,   8'hff,   8'h8e,   8'h8e});
      digit_en = 4'hf;

      // Reset mid-scan at idx=2, prescaler=1
      restart(16'h1234, 4'h0);
      for (int i = 0; i < 8; i++) step();
      chk("pre_midrst", 4'b1011, 8'ha4);
      rst = 1'b1;
      step();
      chk("midrst", 4'hf, 8'hff);
      rst = 1'b0;
      step();
      chk("midrst_release", 4'b1110, 8'hc0);
      frame("midrst_cleared", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                              {8'hc0,   8'hc0,   8'hc0,   8'hc0});

      // Data change without strobe is ignored
      data_in = 16'hffff;
      dp_in   = 4'hf;
      frame("no_strobe", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                         {8'hc0,   8'hc0,   8'hc0,   8'hc0});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
